// File: rtl/dnn_pkg.sv
// -----------------------------------------------------------------------------
// dnn_pkg
// Shared definitions for the feature-map datapath blocks.
//   PIXEL_W            : width of one signed feature-map pixel
//   collector_state_t  : encoding of the feature_map_collector FSM
//   relu_pixel()       : clamps a negative signed pixel to zero
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package dnn_pkg;

    localparam int PIXEL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } collector_state_t;

    function automatic logic [PIXEL_W-1:0] relu_pixel(input logic [PIXEL_W-1:0] px);
        return px[PIXEL_W-1] ? '0 : px;
    endfunction

endpackage

// File: rtl/fmap_ram.sv
// -----------------------------------------------------------------------------
// fmap_ram
// Frame buffer for the feature-map collector: DEPTH x PIXEL_W storage with a
// synchronous write port and a combinational (asynchronous) read port.
// Contents are not reset.
// Ports:
//   i_clk      : clock, write on rising edge
//   i_wr_en    : write enable
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_addr  : read address
//   o_rd_data  : read data, combinational from i_rd_addr
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module fmap_ram
    import dnn_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_wr_en,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [PIXEL_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output logic [PIXEL_W-1:0] o_rd_data
);

    logic [PIXEL_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/feature_map_collector.sv
// -----------------------------------------------------------------------------
// feature_map_collector
// Collects a raster-ordered feature map from an upstream conv/pool stage into a
// frame buffer, then streams it out to a downstream consumer with a
// valid/ready handshake.
//
// Handshake: the upstream side has no backpressure -- every cycle with
// valid_in high is either written or discarded (drop_err). The downstream
// side transfers a pixel on each rising edge where valid_out && ready_in;
// while valid_out is high and ready_in is low, data_out and valid_out hold.
//
// Optional feature: define RELU_EN to clamp negative input pixels to 0 before
// they are stored; without it pixels are stored unmodified.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   valid_in/data_in : upstream pixel stream (signed 8-bit)
//   img_width/height : frame geometry, sampled only on the first pixel in IDLE
//   ready_in         : downstream accepts data_out
//   data_out         : signed output pixel, raster order
//   valid_out        : data_out valid
//   frame_done       : high in the cycle the last pixel is accepted
//   busy             : high in COLLECT and DRAIN
//   drop_err         : one-cycle pulse, the cycle after a discarded sample
//   dbg_state        : current FSM state, for observation
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module feature_map_collector
    import dnn_pkg::*;
#(
    parameter int MAX_PIXELS = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic [PIXEL_W-1:0] data_in,
    input  logic [7:0]         img_width,
    input  logic [7:0]         img_height,
    input  logic               ready_in,
    output logic [PIXEL_W-1:0] data_out,
    output logic               valid_out,
    output logic               frame_done,
    output logic               busy,
    output logic               drop_err,
    output logic [1:0]         dbg_state
);

    localparam int IDX_W  = $clog2(MAX_PIXELS) + 1;
    localparam int ADDR_W = $clog2(MAX_PIXELS);
    localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      MAX_PIX_U = 32'(MAX_PIXELS);

    collector_state_t   r_state;
    collector_state_t   w_state_nxt;

    logic [7:0]         r_width;
    logic [7:0]         r_height;
    logic [IDX_W-1:0]   r_wr_idx;
    logic [IDX_W-1:0]   r_rd_idx;
    logic [PIXEL_W-1:0] r_data_out;
    logic               r_valid_out;
    logic               r_drop_err;

    logic [15:0]        w_total;
    logic [15:0]        w_total_in;
    logic               w_geom_bad;
    logic               w_rd_at_end;
    logic               w_wr_en;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [PIXEL_W-1:0] w_wr_data;
    logic [PIXEL_W-1:0] w_rd_data;
    logic               w_accept_geom;
    logic               w_drop;
    logic               w_load;
    logic               w_finish;

    // Frame size of the latched geometry and of the geometry presented now.
    assign w_total    = 16'(r_width) * 16'(r_height);
    assign w_total_in = 16'(img_width) * 16'(img_height);
    assign w_geom_bad = (img_width == 8'd0) || (img_height == 8'd0) ||
                        ({16'd0, w_total_in} > MAX_PIX_U);

    // rd_idx counts pixels already loaded into data_out.
    assign w_rd_at_end = (16'(r_rd_idx) == w_total);

`ifdef RELU_EN
    assign w_wr_data = relu_pixel(data_in);
`else
    assign w_wr_data = data_in;
`endif

    fmap_ram #(
        .DEPTH  (MAX_PIXELS),
        .ADDR_W (ADDR_W)
    ) u_fmap_ram (
        .i_clk     (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (r_rd_idx[ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

    // ---------------------------------------------------------------------
    // Next-state and control decode
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_en       = 1'b0;
        w_wr_addr     = r_wr_idx[ADDR_W-1:0];
        w_accept_geom = 1'b0;
        w_drop        = 1'b0;
        w_load        = 1'b0;
        w_finish      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (valid_in) begin
                    if (w_geom_bad) begin
                        w_drop = 1'b1;
                    end else begin
                        w_accept_geom = 1'b1;
                        w_wr_en       = 1'b1;
                        w_wr_addr     = '0;
                        w_state_nxt   = (w_total_in == 16'd1) ? ST_DRAIN : ST_COLLECT;
                    end
                end
            end

            ST_COLLECT: begin
                if (valid_in) begin
                    w_wr_en = 1'b1;
                    if (16'(r_wr_idx) == (w_total - 16'd1)) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // The buffer is full; anything arriving now has nowhere to go,
                // including a sample in the cycle the frame finishes.
                if (valid_in) begin
                    w_drop = 1'b1;
                end
                if (r_valid_out && ready_in && w_rd_at_end) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if ((!r_valid_out || ready_in) && !w_rd_at_end) begin
                    w_load = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_width     <= '0;
            r_height    <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_drop_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_drop_err <= w_drop;

            if (w_accept_geom) begin
                r_width  <= img_width;
                r_height <= img_height;
                r_wr_idx <= IDX_ONE;
                r_rd_idx <= '0;
            end else if (w_wr_en) begin
                r_wr_idx <= r_wr_idx + IDX_ONE;
            end

            if (w_load) begin
                r_data_out  <= w_rd_data;
                r_valid_out <= 1'b1;
                r_rd_idx    <= r_rd_idx + IDX_ONE;
            end else if (w_finish) begin
                r_valid_out <= 1'b0;
                r_rd_idx    <= '0;
                r_wr_idx    <= '0;
            end
        end
    end

    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign frame_done = w_finish;
    assign busy       = (r_state != ST_IDLE);
    assign drop_err   = r_drop_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_feature_map_collector.sv
`timescale 1ns/1ps
module tb_feature_map_collector;
    import dnn_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] img_width = '0;
    logic [7:0] img_height = '0;
    logic       ready_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       frame_done;
    logic       busy;
    logic       drop_err;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    feature_map_collector #(.MAX_PIXELS(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .img_width  (img_width),
        .img_height (img_height),
        .ready_in   (ready_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .frame_done (frame_done),
        .busy       (busy),
        .drop_err   (drop_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic [7:0] d);
        valid_in = 1'b1;
        data_in  = d;
        next_cycle();
        valid_in = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] w, input logic [7:0] h, input logic [7:0] first);
        img_width  = w;
        img_height = h;
        for (int i = 0; i < int'(w) * int'(h); i++) begin
            send_pix(8'(int'(first) + i));
            exp_q.push_back(8'(int'(first) + i));
        end
    endtask

    // mode 0: ready_in always high; mode 1: ready_in toggles 1/0.
    // drop_at >= 0 injects one valid_in on that drain cycle.
    task automatic drain(input string tag, input int mode, input int drop_at, input int exp_drops);
        int         cyc = 0;
        bit         done = 0;
        bit         started = 0;
        logic       prev_stall = 0;
        logic [7:0] prev_data = '0;
        logic [7:0] exp;
        int         drops = 0;
        while (!done && cyc < 200) begin
            ready_in = (mode == 0) || (cyc % 2 == 0);
            valid_in = (cyc == drop_at);
            data_in  = 8'h55;
            @(negedge clk);
            if (drop_err) drops++;
            if (valid_out) started = 1;
            if (prev_stall) begin
                check({tag, "_hold_valid"}, 32'(valid_out), 32'd1);
                check({tag, "_hold_data"}, 32'(data_out), 32'(prev_data));
            end
            if (mode == 0 && started && exp_q.size() > 0 && !valid_out)
                check({tag, "_consecutive"}, 32'(valid_out), 32'd1);
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_pixel"}, 32'(data_out), 32'hFFFF_FFFF);
                    done = 1;
                end else begin
                    exp = exp_q.pop_front();
                    check({tag, "_pixel"}, 32'(data_out), 32'(exp));
                    check({tag, "_frame_done"}, 32'(frame_done), 32'(exp_q.size() == 0));
                    if (exp_q.size() == 0) done = 1;
                end
            end else if (frame_done) begin
                check({tag, "_early_frame_done"}, 32'(frame_done), 32'd0);
            end
            prev_stall = valid_out && !ready_in;
            prev_data  = data_out;
            next_cycle();
            valid_in = 1'b0;
            cyc++;
        end
        check({tag, "_drain_complete"}, 32'(done), 32'd1);
        ready_in = 1'b1;
        @(negedge clk);
        if (drop_err) drops++;
        check({tag, "_drops"}, 32'(drops), 32'(exp_drops));
        check({tag, "_end_valid"}, 32'(valid_out), 32'd0);
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
        check({tag, "_end_state"}, 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
        next_cycle();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // reset state
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop_err", 32'(drop_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        next_cycle();
        rst_n = 1'b1;
        ready_in = 1'b1;
        next_cycle();

        // 4x3 frame, values 1..12, ready held high
        img_width = 8'd4; img_height = 8'd3;
        send_pix(8'd1);
        exp_q.push_back(8'd1);
        @(negedge clk);
        check("f43_state_collect", 32'(dbg_state), 32'(ST_COLLECT));
        check("f43_busy", 32'(busy), 32'd1);
        next_cycle();
        for (int i = 2; i <= 12; i++) begin
            send_pix(8'(i));
            exp_q.push_back(8'(i));
        end
        @(negedge clk);
        check("f43_state_drain", 32'(dbg_state), 32'(ST_DRAIN));
        check("f43_no_out_yet", 32'(valid_out), 32'd0);
        next_cycle();
        drain("f43", 0, -1, 0);

        // 2x2 frame with ready toggling
        send_frame(8'd2, 8'd2, 8'd1);
        drain("f22_toggle", 1, -1, 0);

        // 2x2 frame with a stray sample during drain
        send_frame(8'd2, 8'd2, 8'd1);
        drain("f22_drop", 0, 1, 1);

        // 40x40 exceeds the buffer
        img_width = 8'd40; img_height = 8'd40;
        send_pix(8'd9);
        @(negedge clk);
        check("big_drop_err", 32'(drop_err), 32'd1);
        check("big_busy", 32'(busy), 32'd0);
        check("big_valid", 32'(valid_out), 32'd0);
        next_cycle();
        @(negedge clk);
        check("big_drop_once", 32'(drop_err), 32'd0);
        check("big_still_idle", 32'(dbg_state), 32'(ST_IDLE));
        next_cycle();

        // zero width is rejected
        img_width = 8'd0; img_height = 8'd5;
        send_pix(8'd9);
        @(negedge clk);
        check("zero_w_drop_err", 32'(drop_err), 32'd1);
        check("zero_w_busy", 32'(busy), 32'd0);
        next_cycle();

        // 1x1 frame goes straight to DRAIN
        img_width = 8'd1; img_height = 8'd1;
        send_pix(8'd77);
        exp_q.push_back(8'd77);
        @(negedge clk);
        check("one_state_drain", 32'(dbg_state), 32'(ST_DRAIN));
        next_cycle();
        drain("one", 0, -1, 0);

        // 2x1 frame, -5 and 3
        img_width = 8'd2; img_height = 8'd1;
        send_pix(8'hFB);
        send_pix(8'd3);
`ifdef RELU_EN
        exp_q.push_back(8'd0);
`else
        exp_q.push_back(8'hFB);
`endif
        exp_q.push_back(8'd3);
        drain("relu", 0, -1, 0);

        // reset mid-frame after 5 of 12 pixels, then a fresh frame
        img_width = 8'd4; img_height = 8'd3;
        for (int i = 0; i < 5; i++) send_pix(8'(50 + i));
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(valid_out), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        send_frame(8'd4, 8'd3, 8'd101);
        drain("after_rst", 0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
